// File: rtl/spi_master.sv
// SPI master issuing one byte write or one byte read per start/done request to a spiMemory slave.
// Optional: define SPI_MASTER_MISO_SYNC_EN to pass miso_pin through a two-flop synchronizer.
module spi_master #(
    parameter int HALF_DIV = 50,
    parameter int LAG_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk_pin,
    output logic       cs_pin,
    output logic       mosi_pin,
    input  logic       miso_pin,
    output logic [2:0] o_dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [9:0] DIV_LAST  = 10'(HALF_DIV - 1);
    localparam logic [4:0] NB_WR     = 5'd16;
    localparam logic [4:0] NB_RD     = 5'(16 + LAG_BITS);
    // Bit counts above this value are command bits during a read.
    localparam logic [4:0] CMD_FLOOR = 5'(8 + LAG_BITS);

    logic [2:0]  r_state;
    logic [9:0]  r_div;
    logic [4:0]  r_nbits;
    logic [15:0] r_sr;
    logic        r_rw;
    logic [7:0]  r_rx;
    logic [7:0]  r_rdata;
    logic        r_done;
    logic        r_cs;
    logic        r_sclk;
    logic        r_mosi;

    logic        w_miso;
    logic        w_div_end;
    logic [4:0]  w_nbits_dec;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic r_miso_meta;
    logic r_miso_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= miso_pin;
            r_miso_sync <= r_miso_meta;
        end
    end

    assign w_miso = r_miso_sync;
`else
    assign w_miso = miso_pin;
`endif

    assign w_div_end   = (r_div == DIV_LAST);
    assign w_nbits_dec = r_nbits - 5'd1;

    // Lag and read-data bits put 0 on mosi; everything else shifts out the MSB.
    function automatic logic f_drive(input logic i_rw, input logic [4:0] i_n);
        return !i_rw || (i_n > CMD_FLOOR);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_nbits <= '0;
            r_sr    <= '0;
            r_rw    <= 1'b0;
            r_rx    <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sr    <= {addr, rw, (rw ? 8'h00 : wdata)};
                        r_nbits <= rw ? NB_RD : NB_WR;
                        r_rw    <= rw;
                        r_div   <= '0;
                        r_cs    <= 1'b0;
                        r_sclk  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b0;
                        r_mosi  <= f_drive(r_rw, r_nbits) ? r_sr[15] : 1'b0;
                        r_sr    <= {r_sr[14:0], 1'b0};
                        r_state <= S_LOW;
                    end else begin
                        r_div <= r_div + 10'd1;
                    end
                end
                S_LOW: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_div <= r_div + 10'd1;
                    end
                end
                S_HIGH: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_nbits <= w_nbits_dec;
                        if (r_rw && (r_nbits <= 5'd8)) begin
                            r_rx <= {r_rx[6:0], w_miso};
                        end
                        if (r_nbits == 5'd1) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_sclk  <= 1'b0;
                            r_mosi  <= f_drive(r_rw, w_nbits_dec) ? r_sr[15] : 1'b0;
                            r_sr    <= {r_sr[14:0], 1'b0};
                            r_state <= S_LOW;
                        end
                    end else begin
                        r_div <= r_div + 10'd1;
                    end
                end
                S_HOLD: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_cs    <= 1'b1;
                        r_done  <= 1'b1;
                        if (r_rw) begin
                            r_rdata <= r_rx;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 10'd1;
                    end
                end
                default: begin
                    r_div   <= '0;
                    r_cs    <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign sclk_pin    = r_sclk;
    assign cs_pin      = r_cs;
    assign mosi_pin    = r_mosi;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master against a small behavioural spiMemory slave model.
module tb_spi_master;

    localparam int HALF_DIV = 4;
    localparam int LAG      = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       miso_pin = 1'b0;
    logic [2:0] dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    spi_master #(.HALF_DIV(HALF_DIV), .LAG_BITS(LAG)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rw         (rw),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .sclk_pin   (sclk_pin),
        .cs_pin     (cs_pin),
        .mosi_pin   (mosi_pin),
        .miso_pin   (miso_pin),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Slave model: captures mosi on sclk rise, drives miso on sclk fall.
    logic [7:0]  mem [0:127];
    logic [23:0] m_cap = '0;
    logic [7:0]  m_cmd = '0;
    int          m_k = 0;

    always @(negedge cs_pin) begin
        m_k      = 0;
        m_cap    = '0;
        miso_pin = 1'b0;
    end

    always @(posedge sclk_pin) begin
        if (cs_pin === 1'b0) begin
            m_cap = {m_cap[22:0], mosi_pin};
            m_k++;
            if (m_k == 8) m_cmd = m_cap[7:0];
            if (m_k == 16 && !m_cmd[0]) mem[m_cmd[7:1]] = m_cap[7:0];
        end
    end

    always @(negedge sclk_pin) begin
        int bi;
        if (cs_pin === 1'b0 && m_k >= 8 && m_cmd[0]) begin
            if (m_k < 8 + LAG) begin
                miso_pin = 1'b1;
            end else if (m_k < 16 + LAG) begin
                bi = 7 - (m_k - 8 - LAG);
                miso_pin = mem[m_cmd[7:1]][bi];
            end else begin
                miso_pin = 1'b0;
            end
        end else begin
            miso_pin = 1'b0;
        end
    end

    // Pin monitor, sampling the values held during the cycle ending at each edge.
    int cs_low_cnt = 0;
    int done_cnt   = 0;
    int hi_run     = 0;
    int last_gap   = 0;

    always @(posedge clk) begin
        if (cs_pin === 1'b0) begin
            cs_low_cnt++;
            if (hi_run > 0) last_gap = hi_run;
            hi_run = 0;
        end else begin
            hi_run++;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cs_low_cnt = 0;
        done_cnt   = 0;
    endtask

    task automatic txn(input logic i_rw, input logic [6:0] i_addr, input logic [7:0] i_data);
        @(negedge clk);
        rw    = i_rw;
        addr  = i_addr;
        wdata = i_data;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(tag, {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cs",    {31'd0, cs_pin},   32'd1);
        check("rst_sclk",  {31'd0, sclk_pin}, 32'd1);
        check("rst_mosi",  {31'd0, mosi_pin}, 32'd0);
        check("rst_busy",  {31'd0, busy},     32'd0);
        check("rst_done",  {31'd0, done},     32'd0);
        check("rst_rdata", {24'd0, rdata},    32'h00);
        check("rst_state", {29'd0, dbg_state}, 32'd0);

        // Write 0x00 <= 0xFF
        clear_mon();
        txn(1'b0, 7'h00, 8'hFF);
        check("wr1_busy", {31'd0, busy}, 32'd1);
        check("wr1_cs",   {31'd0, cs_pin}, 32'd0);
        wait_done("wr1_done");
        check("wr1_mosi",  {16'd0, m_cap[15:0]}, 32'h00FF);
        check("wr1_edges", m_k, 32'd16);
        check("wr1_cslow", cs_low_cnt, 32'd136);
        check("wr1_ndone", done_cnt, 32'd1);
        check("wr1_rdata", {24'd0, rdata}, 32'h00);
        check("wr1_mem",   {24'd0, mem[0]}, 32'hFF);

        // Read 0x00 (holds 0xFF)
        clear_mon();
        txn(1'b1, 7'h00, 8'h5A);
        wait_done("rd1_done");
        check("rd1_mosi",  {15'd0, m_cap[16:0]}, {15'd0, 8'h01, 9'd0});
        check("rd1_edges", m_k, 32'd17);
        check("rd1_rdata", {24'd0, rdata}, 32'hFF);
        check("rd1_cslow", cs_low_cnt, 32'd144);
        check("rd1_ndone", done_cnt, 32'd1);

        // Read 0x7F (holds 0xA5)
        mem[7'h7F] = 8'hA5;
        clear_mon();
        txn(1'b1, 7'h7F, 8'h00);
        wait_done("rd2_done");
        check("rd2_cmd",   {24'd0, m_cap[16:9]}, 32'hFF);
        check("rd2_rdata", {24'd0, rdata}, 32'hA5);

        // Write 0x35 <= 0x3C leaves rdata alone, then read it back
        clear_mon();
        txn(1'b0, 7'h35, 8'h3C);
        wait_done("wr2_done");
        check("wr2_mosi",  {16'd0, m_cap[15:0]}, 32'h6A3C);
        check("wr2_mem",   {24'd0, mem[7'h35]}, 32'h3C);
        check("wr2_rdata", {24'd0, rdata}, 32'hA5);
        clear_mon();
        txn(1'b1, 7'h35, 8'h00);
        wait_done("rd3_done");
        check("rd3_rdata", {24'd0, rdata}, 32'h3C);

        // Start pulses while busy are ignored
        clear_mon();
        txn(1'b0, 7'h40, 8'h99);
        repeat (8) @(negedge clk);
        rw = 1'b1; addr = 7'h41; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        rw = 1'b0; addr = 7'h42; wdata = 8'h77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_done");
        repeat (20) @(negedge clk);
        check("ign_ndone", done_cnt, 32'd1);
        check("ign_cslow", cs_low_cnt, 32'd136);
        check("ign_mem40", {24'd0, mem[7'h40]}, 32'h99);
        check("ign_mem42", {24'd0, mem[7'h42]}, 32'h00);
        check("ign_busy",  {31'd0, busy}, 32'd0);
        check("ign_rdata", {24'd0, rdata}, 32'h3C);

        // Back-to-back: start held through the done cycle
        clear_mon();
        @(negedge clk);
        rw = 1'b0; addr = 7'h10; wdata = 8'h11; start = 1'b1;
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("b2b_first", {31'd0, done}, 32'd1);
        addr = 7'h11; wdata = 8'h22;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b_done");
        check("b2b_gap",   last_gap, 32'd1);
        check("b2b_ndone", done_cnt, 32'd2);
        check("b2b_cslow", cs_low_cnt, 32'd272);
        check("b2b_mem10", {24'd0, mem[7'h10]}, 32'h11);
        check("b2b_mem11", {24'd0, mem[7'h11]}, 32'h22);

        // Reset during bit 5 of a read
        clear_mon();
        txn(1'b1, 7'h7F, 8'h00);
        t = 0;
        while (!(m_k == 4 && sclk_pin === 1'b0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("abt_reach", {31'd0, sclk_pin}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abt_cs",    {31'd0, cs_pin},   32'd1);
        check("abt_sclk",  {31'd0, sclk_pin}, 32'd1);
        check("abt_busy",  {31'd0, busy},     32'd0);
        check("abt_rdata", {24'd0, rdata},    32'h00);
        check("abt_done",  {31'd0, done},     32'd0);
        repeat (20) @(negedge clk);
        check("abt_ndone", done_cnt, 32'd0);

        // Subsequent write completes normally
        clear_mon();
        txn(1'b0, 7'h22, 8'h5A);
        wait_done("post_done");
        check("post_mem",   {24'd0, mem[7'h22]}, 32'h5A);
        check("post_cslow", cs_low_cnt, 32'd136);
        check("post_ndone", done_cnt, 32'd1);
        check("post_rdata", {24'd0, rdata}, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
